// File: rtl/cordic_atanh_arbiter.sv
// Round-robin front end sharing one atanh core among NUM_REQ requesters.
// Out-of-range samples bypass the core; a tag FIFO returns every response in acceptance order.
module cordic_atanh_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 10,
  parameter int OUT_W   = 32,
  parameter int DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic                    core_in_valid,
  input  logic                    core_in_ready,
  output logic [IN_W-1:0]         core_in_data,
  input  logic                    core_out_valid,
  output logic                    core_out_ready,
  input  logic [OUT_W-1:0]        core_out_data,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic                    busy,
  output logic [15:0]             issued_cnt,
  output logic [15:0]             sat_cnt,
  output logic                    err_orphan
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic signed [IN_W-1:0] POS_LIM = IN_W'(255);
  localparam logic signed [IN_W-1:0] NEG_LIM = IN_W'(-255);

  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            sat;
    logic            sign;
  } tag_t;

  logic [ID_W-1:0]  rr_ptr;
  tag_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full;
  logic             fifo_empty;

  logic             any_valid;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  scan_idx;
  logic [IN_W-1:0]  chosen;
  logic             chosen_sat;
  logic             accept;
  logic             pop;
  tag_t             head;

  assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign busy       = !fifo_empty;

  // First valid requester at or after rr_ptr, scanning upward with wrap.
  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_valid && req_valid[scan_idx]) begin
        any_valid = 1'b1;
        grant     = scan_idx;
      end
    end
  end

  always_comb begin
    chosen = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) chosen = req_data[i*IN_W +: IN_W];
    end
    chosen_sat = ($signed(chosen) > POS_LIM) || ($signed(chosen) < NEG_LIM);
  end

  // rst_n is active-high, so the request side is gated off while it is asserted.
  always_comb begin
    accept        = !rst_n && any_valid && !fifo_full && (chosen_sat || core_in_ready);
    core_in_valid = !rst_n && any_valid && !fifo_full && !chosen_sat;
    core_in_data  = chosen;
    req_ready     = accept ? (NUM_REQ'(1) << grant) : '0;
  end

  // Saturated heads answer locally; in-range heads pass the core result straight through.
  always_comb begin
    head           = fifo_mem[rd_ptr];
    rsp_valid      = '0;
    rsp_data       = '0;
    core_out_ready = 1'b0;
    if (!fifo_empty) begin
      if (head.sat) begin
        rsp_valid[head.id] = 1'b1;
        rsp_data           = head.sign ? SAT_NEG : SAT_POS;
      end else begin
        rsp_valid[head.id] = core_out_valid;
        rsp_data           = core_out_data;
        core_out_ready     = rsp_ready[head.id];
      end
    end
    pop = !fifo_empty && rsp_valid[head.id] && rsp_ready[head.id];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      issued_cnt <= '0;
      sat_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr     <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + ID_W'(1);
        wr_ptr     <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
        issued_cnt <= issued_cnt + 16'd1;
        if (chosen_sat) sat_cnt <= sat_cnt + 16'd1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (fifo_empty && core_out_valid) err_orphan <= 1'b1;
    end
  end

  // Tag storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= '{id: grant, sat: chosen_sat, sign: chosen[IN_W-1]};
    end
  end

endmodule
